// File: rtl/status_frame_tx_if.sv
// status_frame_tx_if
// Groups the protection status inputs and the serial link outputs of the
// status frame transmitter so they can be passed around as one bundle.
//   algorithmEnable  status: algorithm enabled
//   SVMEnable        status: SVM output enabled
//   ADCErr[2:0]      status: per-channel ADC limit faults
//   IGBTErr[3:0]     status: latched driver fault code, 4'hF = no fault
//   txd              UART 8N1 serial output, idle high
//   txBusy           high for the whole duration of a frame
//   frameDone        one-cycle pulse in the last stop-bit cycle of a frame
// master: the status producer / link observer side.
// slave : the transmitter side.
interface status_frame_tx_if;
  logic       algorithmEnable;
  logic       SVMEnable;
  logic [2:0] ADCErr;
  logic [3:0] IGBTErr;
  logic       txd;
  logic       txBusy;
  logic       frameDone;

  modport master (
    output algorithmEnable, SVMEnable, ADCErr, IGBTErr,
    input  txd, txBusy, frameDone
  );

  modport slave (
    input  algorithmEnable, SVMEnable, ADCErr, IGBTErr,
    output txd, txBusy, frameDone
  );
endinterface

// File: rtl/status_frame_tx.sv
// status_frame_tx
// Serialises the live protection status into a 5-byte UART 8N1 frame towards
// the MK/panel link. A frame is requested periodically (heartbeat) and on any
// change of the status inputs; requests are sticky and merge into one frame.
// Frame bytes (each sent LSB first, start/8 data/stop, no gap between bytes):
//   B0 = HEADER
//   B1 = {2'b00, algorithmEnable, SVMEnable, 1'b0, ADCErr}
//   B2 = {4'h0, IGBTErr}
//   B3 = sequence number (increments once per completed frame)
//   B4 = B0 ^ B1 ^ B2 ^ B3
// B1..B3 are captured when the frame starts so a frame is never torn.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    status_frame_tx_if.slave (status inputs, txd/txBusy/frameDone)
module status_frame_tx #(
  parameter int unsigned CLK_DIV      = 434,
  parameter int unsigned FRAME_PERIOD = 500000,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  status_frame_tx_if.slave  bus
);

  localparam int unsigned     DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned     TMR_W      = $clog2(FRAME_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE   = DIV_W'(CLK_DIV - 2);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(FRAME_PERIOD - 1);
  // {alg, svm, adc, igbt} of a healthy, disabled system: no frame is forced
  // out of reset when the inputs sit at these values.
  localparam logic [8:0]      STATUS_RST = {1'b0, 1'b0, 3'b000, 4'hF};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       cur_byte_q, cur_byte_d;
  logic [7:0]       b1_q, b1_d;
  logic [7:0]       b2_q, b2_d;
  logic [7:0]       b3_q, b3_d;
  logic [7:0]       seq_q, seq_d;
  logic             pending_q, pending_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [8:0]       prev_status_q, prev_status_d;
  logic             txd_q, txd_d;
  logic             tx_busy_q, tx_busy_d;
  logic             frame_done_q, frame_done_d;

  logic [8:0] status_now;
  logic       status_changed;
  logic       timer_hit;
  logic       div_last;
  logic [7:0] checksum;
  logic [2:0] next_byte_idx;
  logic [2:0] next_bit_idx;
  logic [7:0] next_byte;

  always_comb begin
    status_now     = {bus.algorithmEnable, bus.SVMEnable, bus.ADCErr, bus.IGBTErr};
    status_changed = (status_now != prev_status_q);
    timer_hit      = (timer_q == TMR_LAST);
    div_last       = (div_cnt_q == DIV_LAST);
    checksum       = HEADER ^ b1_q ^ b2_q ^ b3_q;
    next_byte_idx  = byte_idx_q + 3'd1;
    next_bit_idx   = bit_idx_q + 3'd1;

    case (next_byte_idx)
      3'd1:    next_byte = b1_q;
      3'd2:    next_byte = b2_q;
      3'd3:    next_byte = b3_q;
      default: next_byte = checksum;
    endcase

    state_d       = state_q;
    div_cnt_d     = div_last ? '0 : div_cnt_q + 1'b1;
    bit_idx_d     = bit_idx_q;
    byte_idx_d    = byte_idx_q;
    cur_byte_d    = cur_byte_q;
    b1_d          = b1_q;
    b2_d          = b2_q;
    b3_d          = b3_q;
    seq_d         = seq_q;
    prev_status_d = status_now;
    timer_d       = timer_hit ? '0 : timer_q + 1'b1;
    // Requests are sticky until a frame actually starts, whatever the state.
    pending_d     = pending_q | status_changed | timer_hit;
    txd_d         = txd_q;
    tx_busy_d     = tx_busy_q;
    frame_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (pending_q) begin
          // The snapshot uses the inputs present at this edge, so a change or
          // timer expiry landing on this very edge is already covered by this
          // frame and is dropped together with the old request.
          state_d    = START;
          b1_d       = {2'b00, bus.algorithmEnable, bus.SVMEnable, 1'b0, bus.ADCErr};
          b2_d       = {4'h0, bus.IGBTErr};
          b3_d       = seq_q;
          cur_byte_d = HEADER;
          byte_idx_d = 3'd0;
          pending_d  = 1'b0;
          timer_d    = '0;
          txd_d      = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end

      START: begin
        if (div_last) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          txd_d     = cur_byte_q[0];
        end
      end

      DATA: begin
        if (div_last) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = next_bit_idx;
            txd_d     = cur_byte_q[next_bit_idx];
          end
        end
      end

      STOP: begin
        // frameDone is registered, so it is raised one cycle early to land on
        // the final stop-bit cycle of the checksum byte.
        if (byte_idx_q == 3'd4 && div_cnt_q == DIV_PRE) begin
          frame_done_d = 1'b1;
        end
        if (div_last) begin
          if (byte_idx_q == 3'd4) begin
            state_d   = IDLE;
            tx_busy_d = 1'b0;
            seq_d     = seq_q + 8'd1;
          end else begin
            state_d    = START;
            byte_idx_d = next_byte_idx;
            cur_byte_d = next_byte;
            txd_d      = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state, including the serial line and handshake outputs, is registered
  // here; reset aborts any frame in flight immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      bit_idx_q     <= 3'd0;
      byte_idx_q    <= 3'd0;
      cur_byte_q    <= 8'h00;
      b1_q          <= 8'h00;
      b2_q          <= 8'h00;
      b3_q          <= 8'h00;
      seq_q         <= 8'h00;
      pending_q     <= 1'b0;
      timer_q       <= '0;
      prev_status_q <= STATUS_RST;
      txd_q         <= 1'b1;
      tx_busy_q     <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      bit_idx_q     <= bit_idx_d;
      byte_idx_q    <= byte_idx_d;
      cur_byte_q    <= cur_byte_d;
      b1_q          <= b1_d;
      b2_q          <= b2_d;
      b3_q          <= b3_d;
      seq_q         <= seq_d;
      pending_q     <= pending_d;
      timer_q       <= timer_d;
      prev_status_q <= prev_status_d;
      txd_q         <= txd_d;
      tx_busy_q     <= tx_busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.txd       = txd_q;
  assign bus.txBusy    = tx_busy_q;
  assign bus.frameDone = frame_done_q;

endmodule
